// File: rtl/t03_mem_arbiter.sv
// Two-port round-robin arbiter sharing one external memory bus between CPU (port 0) and a bus master (port 1).
// Latency: grant 1 cycle after the request is seen in IDLE; ack/rdata 0 cycles after mem_ack; IDLE again next cycle.
// Backpressure: requests are level, held until ack; the downstream paces completion with mem_ack.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   req_{read,write,addr,wdata}{0,1} requester ports (read+write together means write)
//   ack0/ack1, err0/err1, rdata      completion pulse, timeout flag and read data to the owner
//   mem_{read,write,addr,wdata}      registered downstream request, held for the whole grant
//   mem_rdata, mem_ack               downstream response
//   busy, owner                      grant outstanding, current or last granted port
//
// Optional feature: define T03_ARB_TIMEOUT_EN to build the busy-cycle watchdog
// (TIMEOUT_CYCLES busy cycles without mem_ack force an ack+err to the owner).

module t03_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read0,
    input  logic              req_write0,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic              req_read1,
    input  logic              req_write1,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              owner
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic rq0, rq1, gnt1;
    logic in_busy, expire, done;

    assign rq0     = req_read0 | req_write0;
    assign rq1     = req_read1 | req_write1;
    // Port 1 wins if it is the only requester, or on a tie when port 0 was served last.
    assign gnt1    = rq1 & (~rq0 | ~last_q);
    assign in_busy = (state_q == S_BUSY);

`ifdef T03_ARB_TIMEOUT_EN
    localparam int CNT_CLOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (CNT_CLOG > 8) ? CNT_CLOG : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // mem_ack in the expiry cycle takes precedence, so expiry requires no ack.
    assign expire = in_busy & ~mem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero while idle, which is equivalent to clearing on grant.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_busy) begin
            cnt_d = '0;
        end else if (!mem_ack && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign expire         = 1'b0;
`endif

    assign done = in_busy & (mem_ack | expire);

    // Next-state: latch the winner's request on grant, release on completion.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (rq0 | rq1) begin
                    state_d = S_BUSY;
                    owner_d = gnt1;
                    last_d  = gnt1;
                    if (gnt1) begin
                        mem_write_d = req_write1;
                        mem_read_d  = req_read1 & ~req_write1;
                        mem_addr_d  = req_addr1;
                        mem_wdata_d = req_wdata1;
                    end else begin
                        mem_write_d = req_write0;
                        mem_read_d  = req_read0 & ~req_write0;
                        mem_addr_d  = req_addr0;
                        mem_wdata_d = req_wdata0;
                    end
                end
            end
            S_BUSY: begin
                // Requester inputs are deliberately ignored here, withdrawal included.
                if (mem_ack | expire) begin
                    state_d     = S_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Completion is steered combinationally to the owner only.
    assign ack0      = done & ~owner_q;
    assign ack1      = done & owner_q;
    assign err0      = expire & ~owner_q;
    assign err1      = expire & owner_q;
    // Read data is forwarded only on a real mem_ack; a timeout returns zero.
    assign rdata     = (in_busy & mem_ack) ? mem_rdata : '0;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = in_busy;
    assign owner     = owner_q;

endmodule

// File: tb/tb_t03_mem_arbiter.sv
// Self-checking bench for t03_mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.

module tb_t03_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_read0, req_write0, req_read1, req_write1;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy, owner;

    always #5 clk = ~clk;

    t03_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_read0(req_read0), .req_write0(req_write0), .req_addr0(req_addr0), .req_wdata0(req_wdata0),
        .req_read1(req_read1), .req_write1(req_write1), .req_addr1(req_addr1), .req_wdata1(req_wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .owner(owner)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: which port holds the bus (-1 = none), who was served last,
    // the latched transaction and the number of unacknowledged busy cycles.
    int            m_own, m_last, m_owner_out, m_cnt;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            grants[$];
    bit            acked[2];
    bit            new_grant;

    task automatic model_reset();
        m_own = -1; m_last = 1; m_owner_out = 0; m_cnt = 0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        acked[0] = 0; acked[1] = 0; new_grant = 0;
    endtask

    task automatic idle_inputs();
        req_read0 = 0; req_write0 = 0; req_read1 = 0; req_write1 = 0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    // One cycle: check outputs against the model, then advance the model with
    // the inputs that the next rising edge will sample.
    task automatic step();
        bit to_hit, done, r0, r1;
        int g;
        #1;
        to_hit = 0;
`ifdef T03_ARB_TIMEOUT_EN
        if (m_own >= 0 && !mem_ack && m_cnt == TO) to_hit = 1;
`endif
        done = (m_own >= 0) && (mem_ack || to_hit);
        chk("busy", busy, m_own >= 0);
        chk("owner", owner, m_owner_out);
        chk("ack0", ack0, done && m_own == 0);
        chk("ack1", ack1, done && m_own == 1);
        chk("err0", err0, to_hit && m_own == 0);
        chk("err1", err1, to_hit && m_own == 1);
        chk("rdata", rdata, (m_own >= 0 && mem_ack) ? mem_rdata : 32'h0);
        chk("mem_read", mem_read, m_own >= 0 && !m_wr);
        chk("mem_write", mem_write, m_own >= 0 && m_wr);
        if (m_own >= 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        acked[0] = done && m_own == 0;
        acked[1] = done && m_own == 1;
        new_grant = 0;
        if (rst) begin
            if (m_own >= 0) begin
                if (done) m_own = -1;
                else m_cnt++;
            end else begin
                r0 = req_read0 | req_write0;
                r1 = req_read1 | req_write1;
                if (r0 || r1) begin
                    if (r0 && r1) g = 1 - m_last;
                    else g = r1 ? 1 : 0;
                    if (g == 0) begin
                        m_wr = req_write0; m_addr = req_addr0; m_wdata = req_wdata0;
                    end else begin
                        m_wr = req_write1; m_addr = req_addr1; m_wdata = req_wdata1;
                    end
                    m_own = g; m_last = g; m_owner_out = g; m_cnt = 0;
                    grants.push_back(g);
                    new_grant = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gstart, n, mwait;
        bit pend[2], t_rd[2], t_wr[2];
        logic [AW-1:0] t_addr[2];
        logic [DW-1:0] t_wd[2];

        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();

        // Reset with mem_ack held high: reset values, no ack.
        mem_ack = 1'b1;
        @(negedge clk);
        repeat (2) step();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        repeat (2) step();
        mem_ack = 1'b0;

        // Port 0 read of 0x40, memory acks 3 cycles after the strobe.
        req_read0 = 1'b1; req_addr0 = 32'h0000_0040;
        step();
        #1 chk("p0_strobe", mem_read, 1'b1);
        repeat (3) step();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("p0_ack0", ack0, 1'b1);
        chk("p0_ack1", ack1, 1'b0);
        chk("p0_rdata", rdata, 32'h1234_5678);
        step();
        mem_ack = 1'b0; req_read0 = 1'b0; mem_rdata = '0;
        step();

        // Both request at the same edge after reset, held continuously.
        do_reset();
        gstart = grants.size();
        req_read0 = 1'b1;
        req_read1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h80; req_wdata1 = 32'hCAFE_F00D;
        for (int c = 0; c < 20; c++) begin
            req_addr0 = $urandom;   // changes mid-BUSY must not reach mem_addr
            mem_ack   = (m_own >= 0);
            mem_rdata = $urandom;
            if (m_own == 1) begin
                #1;
                chk("p1_mem_write", mem_write, 1'b1);
                chk("p1_mem_read", mem_read, 1'b0);
                chk("p1_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            end
            step();
        end
        chk("rr_count", (grants.size() - gstart) >= 6, 1'b1);
        for (int i = 0; i < 6 && gstart + i < grants.size(); i++)
            chk("rr_order", grants[gstart + i], i % 2);
        idle_inputs();
        step();

        // Asynchronous reset mid-BUSY drops strobes at once, no ack.
        req_read0 = 1'b1; req_addr0 = 32'h100;
        step();
        mem_ack = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_mem_read", mem_read, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ack0", ack0, 1'b0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        step();

`ifdef T03_ARB_TIMEOUT_EN
        // No mem_ack: forced completion with err in the (TO+1)-th busy cycle, then port 1.
        do_reset();
        req_read0 = 1'b1; req_read1 = 1'b1;
        step();
        n = 0;
        while (!acked[0] && n < 40) begin
            step();
            n++;
        end
        chk("to_busy_cycles", n, TO + 1);
        step();
        chk("to_next_grant", grants[grants.size() - 1], 1);
        idle_inputs();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
`endif

        // Randomized traffic with random memory latency and spurious idle acks.
        pend[0] = 0; pend[1] = 0; mwait = 0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (acked[p]) pend[p] = 0;
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1;
                    t_rd[p]   = $urandom_range(0, 1);
                    t_wr[p]   = !t_rd[p] || ($urandom_range(0, 1) == 1);
                    t_addr[p] = $urandom;
                    t_wd[p]   = $urandom;
                end
            end
            req_read0 = pend[0] & t_rd[0]; req_write0 = pend[0] & t_wr[0];
            req_addr0 = t_addr[0];         req_wdata0 = t_wd[0];
            req_read1 = pend[1] & t_rd[1]; req_write1 = pend[1] & t_wr[1];
            req_addr1 = t_addr[1];         req_wdata1 = t_wd[1];
            // The owner may scribble on or withdraw its request mid-BUSY.
            if (m_own == 0 && $urandom_range(0, 3) == 0) begin
                req_addr0 = $urandom; req_wdata0 = $urandom; req_read0 = 0; req_write0 = 0;
            end
            if (m_own == 1 && $urandom_range(0, 3) == 0) begin
                req_addr1 = $urandom; req_wdata1 = $urandom; req_read1 = 0; req_write1 = 0;
            end
            mem_rdata = $urandom;
            if (m_own >= 0) begin
                if (mwait == 0) mem_ack = 1'b1;
                else begin
                    mem_ack = 1'b0;
                    mwait--;
                end
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
            step();
            if (new_grant) mwait = $urandom_range(0, 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/t03_mem_arbiter.md
# t03_mem_arbiter

Two-requester arbiter that shares the single external memory bus (read/write/address/data/ack) between the CPU's request unit (port 0) and a secondary bus master such as a display or SPI DMA engine (port 1). It sits between the requesters and the memory interface at the chip boundary. It latches one request per grant and forwards the downstream ack and read data only to the owner. Round-robin priority prevents starvation.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, busy cycles before forced release (used only with T03_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_read0 / req_write0  input  1 each  port 0 (CPU) request, level, held until ack0
- req_addr0  input  ADDR_W  port 0 address
- req_wdata0  input  DATA_W  port 0 write data
- req_read1 / req_write1 / req_addr1 / req_wdata1  input  as port 0  port 1 request
- ack0 / ack1  output  1 each  one-cycle completion pulse to the owner
- err0 / err1  output  1 each  one-cycle timeout pulse, coincident with ack
- rdata  output  DATA_W  shared read data, valid only in an ack cycle
- mem_read / mem_write  output  1 each  downstream strobes
- mem_addr  output  ADDR_W  downstream address
- mem_wdata  output  DATA_W  downstream write data
- mem_rdata  input  DATA_W  downstream read data
- mem_ack  input  1  downstream completion, one-cycle pulse
- busy  output  1  high while a grant is outstanding
- owner  output  1  current or last granted port

## Operation
- States: IDLE and BUSY. A registered `owner` and `last` (the last-served port) qualify BUSY.
- A port is requesting when req_read | req_write. If both strobes are asserted, the request is a write.
- Arbitration in IDLE:
  - If only one port requests, it is granted.
  - If both request, the port ≠ `last` is granted.
  - Reset sets `last` = 1, so port 0 wins the first tie.
- On grant:
  - Latch the owner's addr, wdata and read/write into the mem_* registers.
  - Set owner and last. Enter BUSY.
- In BUSY:
  - mem_* outputs hold their latched values. Requester inputs are ignored, including a withdrawal.
  - When mem_ack=1: ack[owner]=1 combinationally, rdata=mem_rdata, state → IDLE, mem_read/mem_write are cleared at the next edge.
- In IDLE, ack0/ack1 = 0 and rdata = 0. A mem_ack received in IDLE is ignored.
- The non-owner never sees ack or err.
- Reset values: state IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, owner=0, last=1, busy=0, ack*/err*=0, rdata=0. Timeout counter = 0.

## Timing
- Request first seen at edge N in IDLE → mem strobe asserted from cycle N+1. Grant latency is 1 cycle.
- mem_ack in cycle M → ack/rdata in cycle M (0 added latency). IDLE from M+1.
- A request still held at M+1 is regranted, with its strobe at M+2. Minimum per-transaction overhead is 2 cycles beyond the memory latency.
- mem_* strobes remain high during the mem_ack cycle. The downstream side must accept this.
- Both ports requesting continuously → grants strictly alternate 0,1,0,1.
- An asynchronous reset assertion mid-BUSY drops mem_read/mem_write immediately. The transaction is abandoned and no ack is issued.

## Configuration
- T03_ARB_TIMEOUT_EN defined:
  - An 8+ bit counter (width ≥ clog2(TIMEOUT_CYCLES+1)) clears on grant and increments each BUSY cycle without mem_ack.
  - When it equals TIMEOUT_CYCLES with no mem_ack: ack[owner]=1, err[owner]=1, rdata=0 that cycle, and state → IDLE.
  - mem_ack in the same cycle as expiry wins: normal ack, err=0.
- Undefined: no counter is built, err0/err1 are tied 0, and BUSY waits indefinitely for mem_ack.

## Test plan
- Reset with mem_ack held high → all outputs at reset values. No ack0/ack1.
- Port 0 read of 0x0000_0040 alone; memory acks 3 cycles after the strobe with 0x1234_5678 → mem_read rises 1 cycle after the request. ack0 pulses once with rdata=0x1234_5678. ack1 stays 0.
- Both ports request at the same edge after reset → port 0 is granted first, then port 1. Holding both requests → grant order 0,1,0,1.
- Port 1 asserts read and write together with wdata=0xCAFE_F00D → mem_write=1, mem_read=0, mem_wdata=0xCAFE_F00D.
- Port 0 changes req_addr0 mid-BUSY → mem_addr keeps its latched value until ack.
- With T03_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mem_ack → ack0 and err0 pulse together 8 cycles after grant, rdata=0, and port 1 is granted next.
